hazard_scoreboard: RTL and testbench

- Parametrised hazard tracker for the in-order RISC-V pipeline. It sits beside the decode-stage control unit.
- It records the destination register and hazard optype (none/ALU/LOAD/STORE) of every instruction in flight downstream of ID, over a configurable pipeline depth and load latency.
- From that record it produces load-use stall requests and per-operand forwarding selects for the ID instruction.
- It generalises the fixed-depth, ALU/LOAD-only hazard logic and adds pipeline hold, flush and a stall performance counter.

---
 rtl/hazard_scoreboard_pkg.sv | 20 ++
 rtl/hazard_scoreboard_match.sv | 34 +++
 rtl/hazard_scoreboard.sv | 95 +++++++++
 tb/tb_hazard_scoreboard.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/hazard_scoreboard_pkg.sv
// hazard_scoreboard_pkg: shared control-unit constants, optype encodings and scoreboard slot type
package hazard_scoreboard_pkg;

    localparam int RA_W_MAX = 8;

    typedef enum logic [1:0] {
        OPT_NONE  = 2'b00,
        OPT_ALU   = 2'b01,
        OPT_LOAD  = 2'b10,
        OPT_STORE = 2'b11
    } opt_e;

    // rd is held at the widest supported width so the type can be shared by any RA_W <= RA_W_MAX
    typedef struct packed {
        logic                valid;
        logic [RA_W_MAX-1:0] rd;
        logic                is_load;
    } slot_t;

endpackage

// File: rtl/hazard_scoreboard_match.sv
// hazard_match: youngest-first match of one source register against the tracked slots
// Ports: slots (tracked pipeline slots, index 0 youngest), rs (source register),
//        en (operand really read by a valid ID instruction),
//        hit / idx / is_load (winning slot present, its index, whether it is a load)
module hazard_match
    import hazard_scoreboard_pkg::*;
#(
    parameter int DEPTH = 3,
    parameter int RA_W  = 5,
    parameter int IDX_W = 2
) (
    input  slot_t             slots [DEPTH],
    input  logic [RA_W-1:0]   rs,
    input  logic              en,
    output logic              hit,
    output logic [IDX_W-1:0]  idx,
    output logic              is_load
);

    // Scan oldest to youngest so the lowest matching index is the one left standing
    always_comb begin
        hit     = 1'b0;
        idx     = '0;
        is_load = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (en && rs != '0 && slots[i].valid && slots[i].rd == RA_W_MAX'(rs)) begin
                hit     = 1'b1;
                idx     = IDX_W'(i);
                is_load = slots[i].is_load;
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: tracks in-flight writers after ID; produces load-use stall and forwarding selects
// Ports: clk, rst (sync active-high); id_* (ID-stage instruction fields); hold (freeze), flush (kill slots);
//        stall (load-use stall request); rsX_fwd (0 = regfile, k = slot k-1); rsX_fwd_load (take load data);
//        stall_cnt (saturating stall cycle count)
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int DEPTH    = 3,
    parameter int LOAD_LAT = 1,
    parameter int RA_W     = 5,
    parameter int CNT_W    = 16,
    localparam int FW      = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [RA_W-1:0]  id_rs1,
    input  logic [RA_W-1:0]  id_rs2,
    input  logic             id_rs1use,
    input  logic             id_rs2use,
    input  logic [RA_W-1:0]  id_rd,
    input  logic             id_regwrite,
    input  logic [1:0]       id_optype,
    input  logic             hold,
    input  logic             flush,
    output logic             stall,
    output logic [FW-1:0]    rs1_fwd,
    output logic [FW-1:0]    rs2_fwd,
    output logic             rs1_fwd_load,
    output logic             rs2_fwd_load,
    output logic [CNT_W-1:0] stall_cnt
);

    slot_t            slot_q [DEPTH];
    slot_t            slot_d [DEPTH];
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic          hit1, hit2, ld1, ld2, haz1, haz2;
    logic [FW-1:0] idx1, idx2;

    hazard_match #(.DEPTH(DEPTH), .RA_W(RA_W), .IDX_W(FW)) u_match_rs1 (
        .slots   (slot_q),
        .rs      (id_rs1),
        .en      (id_valid & id_rs1use),
        .hit     (hit1),
        .idx     (idx1),
        .is_load (ld1)
    );

    hazard_match #(.DEPTH(DEPTH), .RA_W(RA_W), .IDX_W(FW)) u_match_rs2 (
        .slots   (slot_q),
        .rs      (id_rs2),
        .en      (id_valid & id_rs2use),
        .hit     (hit2),
        .idx     (idx2),
        .is_load (ld2)
    );

    // A load is only a hazard while it sits in a slot earlier than where its data appears
    always_comb begin
        haz1         = hit1 & ld1 & (idx1 < FW'(LOAD_LAT));
        haz2         = hit2 & ld2 & (idx2 < FW'(LOAD_LAT));
        stall        = (haz1 | haz2) & ~flush;
        rs1_fwd      = hit1 ? idx1 + FW'(1) : '0;
        rs2_fwd      = hit2 ? idx2 + FW'(1) : '0;
        rs1_fwd_load = hit1 & ld1;
        rs2_fwd_load = hit2 & ld2;
    end

    always_comb begin
        slot_d      = slot_q;
        stall_cnt_d = (stall && !hold && stall_cnt_q != '1) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
        if (flush) begin
            for (int i = 0; i < DEPTH; i++) slot_d[i] = '0;
        end else if (!hold) begin
            for (int i = DEPTH - 1; i > 0; i--) slot_d[i] = slot_q[i-1];
            slot_d[0] = stall ? '0 : '{valid:   id_valid & id_regwrite,
                                       rd:      RA_W_MAX'(id_rd),
                                       is_load: id_optype == OPT_LOAD};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) slot_q[i] <= '0;
            stall_cnt_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) slot_q[i] <= slot_d[i];
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed checks of two scoreboard configurations
module tb_hazard_scoreboard;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       id_valid = 1'b0;
    logic [4:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
    logic       id_rs1use = 1'b0, id_rs2use = 1'b0, id_regwrite = 1'b0;
    logic [1:0] id_optype = 2'b00;
    logic       hold = 1'b0, flush = 1'b0;

    logic        a_stall, a_l1, a_l2;
    logic [1:0]  a_f1, a_f2;
    logic [15:0] a_cnt;
    logic        b_stall, b_l1, b_l2;
    logic [2:0]  b_f1, b_f2;
    logic [1:0]  b_cnt;

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    hazard_scoreboard #(.DEPTH(3), .LOAD_LAT(1), .RA_W(5), .CNT_W(16)) u_a (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1use(id_rs1use), .id_rs2use(id_rs2use), .id_rd(id_rd), .id_regwrite(id_regwrite),
        .id_optype(id_optype), .hold(hold), .flush(flush), .stall(a_stall),
        .rs1_fwd(a_f1), .rs2_fwd(a_f2), .rs1_fwd_load(a_l1), .rs2_fwd_load(a_l2), .stall_cnt(a_cnt)
    );

    hazard_scoreboard #(.DEPTH(5), .LOAD_LAT(3), .RA_W(5), .CNT_W(2)) u_b (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1use(id_rs1use), .id_rs2use(id_rs2use), .id_rd(id_rd), .id_regwrite(id_regwrite),
        .id_optype(id_optype), .hold(hold), .flush(flush), .stall(b_stall),
        .rs1_fwd(b_f1), .rs2_fwd(b_f2), .rs1_fwd_load(b_l1), .rs2_fwd_load(b_l2), .stall_cnt(b_cnt)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input int rd, input int op, input int rs1, input int u1, input int rs2, input int u2);
        id_valid    = 1'b1;
        id_rd       = 5'(rd);
        id_optype   = 2'(op);
        id_regwrite = (op == 1 || op == 2);
        id_rs1      = 5'(rs1);
        id_rs1use   = 1'(u1);
        id_rs2      = 5'(rs2);
        id_rs2use   = 1'(u2);
        #1;
    endtask

    initial begin
        step();
        step();
        check("rst_stall", a_stall, 0);
        check("rst_fwd1", a_f1, 0);
        check("rst_fwd2", a_f2, 0);
        check("rst_load1", a_l1, 0);
        check("rst_cnt", a_cnt, 0);
        rst = 1'b0;

        // ALU chain on DEPTH=3, LOAD_LAT=1
        set_id(5, 1, 1, 1, 2, 1);
        check("alu0_fwd1", a_f1, 0);
        step();
        set_id(6, 1, 5, 1, 1, 1);
        check("alu1_stall", a_stall, 0);
        check("alu1_fwd1", a_f1, 1);
        check("alu1_load1", a_l1, 0);
        check("alu1_fwd2", a_f2, 0);
        step();
        set_id(10, 1, 5, 1, 0, 1);
        check("alu2_fwd1", a_f1, 2);
        check("alu2_fwd2", a_f2, 0);
        step();

        // Load-use with one stall cycle
        set_id(7, 2, 1, 1, 0, 0);
        step();
        set_id(8, 1, 7, 1, 7, 1);
        check("lu_stall", a_stall, 1);
        check("lu_cnt0", a_cnt, 0);
        step();
        check("lu_cnt1", a_cnt, 1);
        check("lu_stall_gone", a_stall, 0);
        check("lu_fwd1", a_f1, 2);
        check("lu_fwd2", a_f2, 2);
        check("lu_load1", a_l1, 1);
        check("lu_load2", a_l2, 1);
        step();

        // Youngest writer wins; x0 never forwards or stalls
        set_id(9, 1, 1, 1, 2, 1);
        step();
        set_id(11, 1, 1, 1, 2, 1);
        step();
        set_id(9, 1, 1, 1, 2, 1);
        step();
        set_id(12, 1, 9, 1, 0, 1);
        check("prio_fwd1", a_f1, 1);
        check("prio_fwd2", a_f2, 0);
        step();
        set_id(0, 2, 1, 1, 0, 0);
        step();
        set_id(13, 1, 0, 1, 0, 1);
        check("x0_stall", a_stall, 0);
        check("x0_fwd1", a_f1, 0);
        check("x0_fwd2", a_f2, 0);
        step();

        // Hold frozen over a load-use stall
        set_id(14, 2, 1, 1, 0, 0);
        step();
        set_id(15, 1, 14, 1, 1, 1);
        check("hold_pre_stall", a_stall, 1);
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("hold_stall", a_stall, 1);
            check("hold_cnt", a_cnt, 1);
        end
        hold = 1'b0;
        #1;
        check("hold_rel_stall", a_stall, 1);
        step();
        check("hold_res_cnt", a_cnt, 2);
        check("hold_res_stall", a_stall, 0);
        check("hold_res_fwd1", a_f1, 2);
        check("hold_res_load1", a_l1, 1);
        step();

        // Flush beats stall
        set_id(16, 2, 1, 1, 0, 0);
        step();
        set_id(17, 1, 16, 1, 16, 1);
        check("fl_pre_stall", a_stall, 1);
        flush = 1'b1;
        #1;
        check("fl_stall", a_stall, 0);
        step();
        flush = 1'b0;
        #1;
        check("fl_cnt", a_cnt, 2);
        check("fl_post_stall", a_stall, 0);
        check("fl_fwd1", a_f1, 0);
        check("fl_fwd2", a_f2, 0);
        check("fl_load1", a_l1, 0);
        step();

        // Unused operands and invalid ID never match
        set_id(18, 2, 1, 1, 0, 0);
        step();
        set_id(19, 1, 18, 0, 17, 1);
        check("use_stall", a_stall, 0);
        check("use_fwd1", a_f1, 0);
        check("use_fwd2", a_f2, 2);
        set_id(19, 1, 18, 1, 0, 0);
        id_valid = 1'b0;
        #1;
        check("inv_stall", a_stall, 0);
        check("inv_fwd1", a_f1, 0);

        // DEPTH=5, LOAD_LAT=3, CNT_W=2
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("b_rst_cnt", b_cnt, 0);
        set_id(3, 2, 1, 1, 0, 0);
        step();
        set_id(4, 1, 3, 1, 0, 1);
        for (int i = 0; i < 3; i++) begin
            check("b_stall", b_stall, 1);
            check("b_cnt", b_cnt, i);
            step();
        end
        check("b_stall_done", b_stall, 0);
        check("b_fwd1", b_f1, 4);
        check("b_load1", b_l1, 1);
        check("b_cnt3", b_cnt, 3);
        step();
        set_id(20, 2, 1, 1, 0, 0);
        step();
        set_id(21, 1, 20, 1, 0, 1);
        for (int i = 0; i < 3; i++) begin
            check("b_sat_stall", b_stall, 1);
            step();
        end
        check("b_sat_cnt", b_cnt, 3);
        check("b_sat_fwd1", b_f1, 4);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
